rx_dest_reader: RTL and testbench
=================================

Name: rx_dest_reader

Overview:
- Drain side of the TX path: consumes words from destination FIFOs D0 and D1 via their POP strobes and merges them into one VALID/READY output stream.
- Fair round-robin arbitration, small output buffer, per-destination word counters, sticky routing-error flag.
- Sits between the TX top's D0/D1 FIFO outputs and the downstream consumer (link serializer or checker).
- Word format: [5] destination, [4] VC, [3:0] payload.

Parameters:
- DATA_W, 6, word width.
- BUF_DEPTH, 2, output buffer entries (power of 2, >=2).
- CNT_W, 8, width of per-destination word counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  level; 0 blocks new pops; in-flight word and buffer still drain.
- D0_EMPTY  in  1  D0 FIFO empty.
- D1_EMPTY  in  1  D1 FIFO empty.
- D0_DATA  in  DATA_W  D0 FIFO read data, valid 1 cycle after POP_D0.
- D1_DATA  in  DATA_W  D1 FIFO read data, valid 1 cycle after POP_D1.
- POP_D0  out  1  single-cycle pop strobe to D0.
- POP_D1  out  1  single-cycle pop strobe to D1.
- DATA_OUT  out  DATA_W  head of output buffer.
- VALID_OUT  out  1  DATA_OUT valid.
- READY_IN  in  1  consumer accepts when VALID_OUT && READY_IN.
- SRC_OUT  out  1  source FIFO of head word (0=D0, 1=D1).
- CNT_D0  out  CNT_W  words delivered from D0.
- CNT_D1  out  CNT_W  words delivered from D1.
- ERR_DEST  out  1  sticky: word bit[5] disagreed with source FIFO.

Behaviour:
- Reset (RESET=1 at posedge): all outputs 0, buffer empty, in-flight cleared, RR pointer -> D0. Reset mid-pop discards the in-flight word. The FIFOs are reset by the same RESET.
- Pop grant at a cycle requires:
  - ENABLE=1;
  - credit: occupancy + inflight < BUF_DEPTH, where occupancy is sampled after this cycle's consume;
  - at most one of POP_D0/POP_D1 high per cycle, and never POP_Dx while Dx_EMPTY=1.
- Arbitration:
  - Both non-empty: grant the RR pointer's side, then the pointer toggles to the other side.
  - Only one non-empty: grant it; the pointer moves to the side not granted.
- Capture: the cycle after POP_Dx, Dx_DATA is written into the buffer with src=x. Pop-to-VALID_OUT latency is 2 cycles when the buffer is empty (pop at edge N, write at N+1, VALID_OUT high after N+1).
- Back-to-back: with READY_IN=1 and both FIFOs non-empty, one pop per cycle, alternating D0,D1,D0,... Full throughput needs BUF_DEPTH>=2.
- Output buffer: circular, rd/wr pointers wrap at BUF_DEPTH.
  - VALID_OUT = occupancy != 0.
  - DATA_OUT/SRC_OUT show the head entry.
  - Simultaneous write and consume keep occupancy constant.
  - DATA_OUT is held stable while VALID_OUT && !READY_IN.
- Counters: CNT_Dx increments on handshake (VALID_OUT && READY_IN) when SRC_OUT=x; wraps modulo 2^CNT_W.
- ERR_DEST: set on capture when word[5] != src. Cleared only by RESET. The word is still delivered.
- FSM (per side, in-flight tracker):
  - IDLE -> POPPED on grant.
  - POPPED -> IDLE on capture, or -> POPPED again if re-granted the same cycle.
  - Credit accounting uses a 1-bit inflight flag.
- ENABLE deassert mid-operation: no new grants; the POPPED word is still captured.

Decomposition:
- Shared package rx_pkg: DATA_W, bit-field constants DEST_BIT=5, VC_BIT=4, PAYLOAD_MSB=3; SRC_D0=0 / SRC_D1=1 encoding.
- One sub-module: rx_out_buf (circular buffer with occupancy, parameterised DATA_W+1 wide, BUF_DEPTH).
- Arbiter, credit logic and counters stay in the top.

Test Plan:
- Reset then D0 holds 'b001010, D1 empty, READY_IN=1 -> POP_D0 one cycle, 2 cycles later VALID_OUT=1, DATA_OUT='b001010, SRC_OUT=0, CNT_D0=1, ERR_DEST=0.
- D0 holds 3 words and D1 holds 3 words (bit5=1, e.g. 'b111110), READY_IN=1 -> pops alternate D0,D1,D0,D1,D0,D1 on consecutive cycles; CNT_D0=3, CNT_D1=3.
- READY_IN=0 with both non-empty -> exactly BUF_DEPTH=2 pops total; DATA_OUT stable; POP_Dx never high while Dx_EMPTY=1.
- D0 delivers 'b111110 (bit5=1) -> ERR_DEST rises the cycle after capture, stays 1 through later clean words until RESET.
- 256 words from D1 with CNT_W=8 -> CNT_D1 wraps to 0.
- RESET asserted the cycle after POP_D1 -> word not captured, VALID_OUT=0, counters 0.
- ENABLE=0 the cycle after a pop -> the popped word still appears on DATA_OUT, no further pops.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the TX-path drain side (rx_dest_reader and its output buffer).
//   Word layout: [DEST_BIT] destination, [VC_BIT] virtual channel, [PAYLOAD_MSB:0] payload.
//   SRC_D0/SRC_D1 encode which destination FIFO a word was popped from.
package rx_pkg;

  localparam int unsigned DATA_W      = 6;
  localparam int unsigned PAYLOAD_MSB = 3;
  localparam int unsigned VC_BIT      = PAYLOAD_MSB + 1;
  localparam int unsigned DEST_BIT    = VC_BIT + 1;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

  // Per-side in-flight tracker: a pop has been issued, its data arrives next cycle.
  typedef enum logic {
    StIdle,
    StPopped
  } pop_st_e;

  // A word popped from FIFO x must carry destination x in its header bit.
  function automatic logic dest_mismatch(logic dest, logic src);
    return dest != src;
  endfunction

endpackage

// File: rtl/rx_out_buf.sv
// Small circular output buffer with occupancy count.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset (empties buffer, clears entries)
//   wr_en   : write wr_data at the tail (caller guarantees space)
//   wr_data : entry to write
//   rd_en   : consume the head entry (ignored when empty)
//   rd_data : head entry
//   occ     : number of stored entries (0..DEPTH)
module rx_out_buf #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned OccW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [OccW-1:0]  occ
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [OccW-1:0]  occ_q;
  logic             rd_ok;

  assign rd_ok = rd_en && (occ_q != '0);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_ok})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign occ     = occ_q;

endmodule

// File: rtl/rx_dest_reader.sv
// Drains destination FIFOs D0/D1 into one VALID/READY stream.
//   clk, RESET          : clock and synchronous active-high reset
//   ENABLE              : gates new pops; in-flight word and buffer still drain
//   D0_EMPTY, D1_EMPTY  : FIFO empty flags
//   D0_DATA, D1_DATA    : FIFO read data, valid the cycle after the matching pop
//   POP_D0, POP_D1      : single-cycle pop strobes (at most one per cycle)
//   DATA_OUT, SRC_OUT   : head word and the FIFO it came from
//   VALID_OUT, READY_IN : output handshake
//   CNT_D0, CNT_D1      : delivered-word counters per source (wrapping)
//   ERR_DEST            : sticky, a word's destination bit disagreed with its source
module rx_dest_reader #(
  parameter int unsigned DATA_W    = rx_pkg::DATA_W,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              D0_EMPTY,
  input  logic              D1_EMPTY,
  input  logic [DATA_W-1:0] D0_DATA,
  input  logic [DATA_W-1:0] D1_DATA,
  output logic              POP_D0,
  output logic              POP_D1,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              VALID_OUT,
  input  logic              READY_IN,
  output logic              SRC_OUT,
  output logic [CNT_W-1:0]  CNT_D0,
  output logic [CNT_W-1:0]  CNT_D1,
  output logic              ERR_DEST
);

  import rx_pkg::*;

  localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);

  pop_st_e          st_d0_q, st_d1_q;
  logic             rr_q;           // side favoured when both FIFOs have data
  logic [CNT_W-1:0] cnt_d0_q, cnt_d1_q;
  logic             err_q;

  logic              consume;
  logic              inflight;
  logic [31:0]       level;
  logic              credit;
  logic              pop_d0, pop_d1;
  logic              wr_en;
  logic              wr_src;
  logic [DATA_W-1:0] wr_word;
  logic [OccW-1:0]   occ;
  logic [DATA_W:0]   head;

  assign consume  = VALID_OUT && READY_IN;
  assign inflight = (st_d0_q == StPopped) || (st_d1_q == StPopped);

  // Reserve a slot for every word already popped; occupancy counts after this
  // cycle's consume so a full buffer being drained still sustains one pop per cycle.
  assign level  = 32'(occ) - 32'(consume) + 32'(inflight);
  assign credit = level < BUF_DEPTH;

  always_comb begin
    pop_d0 = 1'b0;
    pop_d1 = 1'b0;
    if (!RESET && ENABLE && credit) begin
      if (!D0_EMPTY && !D1_EMPTY) begin
        if (rr_q == SRC_D0) begin
          pop_d0 = 1'b1;
        end else begin
          pop_d1 = 1'b1;
        end
      end else if (!D0_EMPTY) begin
        pop_d0 = 1'b1;
      end else if (!D1_EMPTY) begin
        pop_d1 = 1'b1;
      end
    end
  end

  // Data of a popped word is on Dx_DATA exactly one cycle later.
  assign wr_en   = inflight;
  assign wr_src  = (st_d1_q == StPopped) ? SRC_D1 : SRC_D0;
  assign wr_word = (st_d1_q == StPopped) ? D1_DATA : D0_DATA;

  always_ff @(posedge clk) begin
    if (RESET) begin
      st_d0_q  <= StIdle;
      st_d1_q  <= StIdle;
      rr_q     <= SRC_D0;
      cnt_d0_q <= '0;
      cnt_d1_q <= '0;
      err_q    <= 1'b0;
    end else begin
      // Popped returns to Idle on capture unless re-granted in the same cycle.
      case (st_d0_q)
        StIdle:   if (pop_d0) st_d0_q <= StPopped;
        StPopped: if (!pop_d0) st_d0_q <= StIdle;
        default:  st_d0_q <= StIdle;
      endcase
      case (st_d1_q)
        StIdle:   if (pop_d1) st_d1_q <= StPopped;
        StPopped: if (!pop_d1) st_d1_q <= StIdle;
        default:  st_d1_q <= StIdle;
      endcase

      // After any grant the pointer favours the side that was not granted.
      if (pop_d0) begin
        rr_q <= SRC_D1;
      end else if (pop_d1) begin
        rr_q <= SRC_D0;
      end

      if (consume) begin
        if (SRC_OUT == SRC_D1) begin
          cnt_d1_q <= cnt_d1_q + 1'b1;
        end else begin
          cnt_d0_q <= cnt_d0_q + 1'b1;
        end
      end

      if (wr_en && dest_mismatch(wr_word[DEST_BIT], wr_src)) begin
        err_q <= 1'b1;
      end
    end
  end

  rx_out_buf #(
    .WIDTH(DATA_W + 1),
    .DEPTH(BUF_DEPTH)
  ) u_out_buf (
    .clk     (clk),
    .rst     (RESET),
    .wr_en   (wr_en),
    .wr_data ({wr_src, wr_word}),
    .rd_en   (consume),
    .rd_data (head),
    .occ     (occ)
  );

  assign POP_D0    = pop_d0;
  assign POP_D1    = pop_d1;
  assign VALID_OUT = (occ != '0);
  assign SRC_OUT   = head[DATA_W];
  assign DATA_OUT  = head[DATA_W-1:0];
  assign CNT_D0    = cnt_d0_q;
  assign CNT_D1    = cnt_d1_q;
  assign ERR_DEST  = err_q;

endmodule

// File: tb/tb_rx_dest_reader.sv
// Self-checking bench for rx_dest_reader: behavioural D0/D1 FIFOs, expected-word
// scoreboard filled when words are queued, checked on every output handshake.
module tb_rx_dest_reader;

  logic       clk = 1'b0;
  logic       RESET, ENABLE, READY_IN;
  logic       D0_EMPTY, D1_EMPTY;
  logic [5:0] D0_DATA = '0, D1_DATA = '0;
  logic       POP_D0, POP_D1, VALID_OUT, SRC_OUT, ERR_DEST;
  logic [5:0] DATA_OUT;
  logic [7:0] CNT_D0, CNT_D1;

  always #5 clk = ~clk;

  rx_dest_reader #(
    .DATA_W   (6),
    .BUF_DEPTH(2),
    .CNT_W    (8)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .D0_EMPTY (D0_EMPTY),
    .D1_EMPTY (D1_EMPTY),
    .D0_DATA  (D0_DATA),
    .D1_DATA  (D1_DATA),
    .POP_D0   (POP_D0),
    .POP_D1   (POP_D1),
    .DATA_OUT (DATA_OUT),
    .VALID_OUT(VALID_OUT),
    .READY_IN (READY_IN),
    .SRC_OUT  (SRC_OUT),
    .CNT_D0   (CNT_D0),
    .CNT_D1   (CNT_D1),
    .ERR_DEST (ERR_DEST)
  );

  // FIFO models: read data registered one cycle after the pop, flushed by RESET.
  logic [5:0] mem0 [1024];
  logic [5:0] mem1 [1024];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;

  assign D0_EMPTY = (rd0 >= wr0);
  assign D1_EMPTY = (rd1 >= wr1);

  always @(posedge clk) begin
    if (RESET) begin
      rd0 <= wr0;
      rd1 <= wr1;
    end else begin
      if (POP_D0 && rd0 < wr0) begin
        D0_DATA <= mem0[rd0];
        rd0     <= rd0 + 1;
      end
      if (POP_D1 && rd1 < wr1) begin
        D1_DATA <= mem1[rd1];
        rd1     <= rd1 + 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_d0    = 0;
  int hs_d1    = 0;
  logic [6:0] exp_q[$];
  logic       pop_log[$];
  int         pop_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic fifo_push(input logic side, input logic [5:0] w);
    if (side) begin
      mem1[wr1] = w;
      wr1++;
    end else begin
      mem0[wr0] = w;
      wr0++;
    end
  endtask

  task automatic expect_word(input logic src, input logic [5:0] w);
    exp_q.push_back({src, w});
  endtask

  // One clock: sample at negedge (pop legality, scoreboard), then step past posedge.
  task automatic tick();
    logic [6:0] e;
    @(negedge clk);
    check_eq("pop_d0_while_empty", {31'd0, POP_D0 & D0_EMPTY}, 0);
    check_eq("pop_d1_while_empty", {31'd0, POP_D1 & D1_EMPTY}, 0);
    check_eq("pop_both", {31'd0, POP_D0 & POP_D1}, 0);
    if (POP_D0 || POP_D1) begin
      pop_log.push_back(POP_D1);
      pop_cyc.push_back(cyc);
    end
    if (VALID_OUT && READY_IN) begin
      check_eq("sb_pending", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("sb_word", {25'd0, SRC_OUT, DATA_OUT}, {25'd0, e});
      end
      if (SRC_OUT) hs_d1++;
      else hs_d0++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    exp_q.delete();
    pop_log.delete();
    pop_cyc.delete();
    hs_d0 = 0;
    hs_d1 = 0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (n < max_cyc &&
           !(exp_q.size() == 0 && !VALID_OUT && D0_EMPTY && D1_EMPTY)) begin
      tick();
      n++;
    end
    check_eq("drain_in_time", {31'd0, n < max_cyc}, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [5:0] wa [3];
  logic [5:0] wb [3];

  initial begin
    wa[0] = 6'b001010; wa[1] = 6'b000001; wa[2] = 6'b010111;
    wb[0] = 6'b111110; wb[1] = 6'b100000; wb[2] = 6'b110101;
    RESET = 1'b1; ENABLE = 1'b0; READY_IN = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check_eq("rst_valid", {31'd0, VALID_OUT}, 0);
    check_eq("rst_data", {26'd0, DATA_OUT}, 0);
    check_eq("rst_src", {31'd0, SRC_OUT}, 0);
    check_eq("rst_cnt_d0", {24'd0, CNT_D0}, 0);
    check_eq("rst_cnt_d1", {24'd0, CNT_D1}, 0);
    check_eq("rst_err", {31'd0, ERR_DEST}, 0);
    ENABLE = 1'b1;

    // Single word from D0: pop, capture next edge, VALID after it
    fifo_push(1'b0, 6'b001010);
    expect_word(1'b0, 6'b001010);
    tick();
    check_eq("t1_valid_after_pop", {31'd0, VALID_OUT}, 0);
    tick();
    check_eq("t1_valid_after_cap", {31'd0, VALID_OUT}, 1);
    check_eq("t1_data", {26'd0, DATA_OUT}, 32'b001010);
    check_eq("t1_src", {31'd0, SRC_OUT}, 0);
    tick();
    check_eq("t1_cnt_d0", {24'd0, CNT_D0}, 1);
    check_eq("t1_err", {31'd0, ERR_DEST}, 0);
    check_eq("t1_pops", pop_log.size(), 1);
    check_eq("t1_pop_side", {31'd0, pop_log[0]}, 0);

    // Both sides loaded: alternating back-to-back pops starting with D0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fifo_push(1'b0, wa[i]);
      fifo_push(1'b1, wb[i]);
    end
    for (int i = 0; i < 3; i++) begin
      expect_word(1'b0, wa[i]);
      expect_word(1'b1, wb[i]);
    end
    drain(40);
    check_eq("t2_pops", pop_log.size(), 6);
    for (int i = 0; i < pop_log.size(); i++) begin
      check_eq("t2_pop_side", {31'd0, pop_log[i]}, i % 2);
      check_eq("t2_pop_cycle", pop_cyc[i] - pop_cyc[0], i);
    end
    check_eq("t2_cnt_d0", {24'd0, CNT_D0}, 3);
    check_eq("t2_cnt_d1", {24'd0, CNT_D1}, 3);
    check_eq("t2_err", {31'd0, ERR_DEST}, 0);

    // Back-pressure: only BUF_DEPTH pops, head held stable
    do_reset();
    READY_IN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fifo_push(1'b0, wa[i]);
      fifo_push(1'b1, wb[i]);
    end
    for (int i = 0; i < 3; i++) begin
      expect_word(1'b0, wa[i]);
      expect_word(1'b1, wb[i]);
    end
    tick();
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      check_eq("t3_valid_held", {31'd0, VALID_OUT}, 1);
      check_eq("t3_data_held", {26'd0, DATA_OUT}, {26'd0, wa[0]});
      check_eq("t3_src_held", {31'd0, SRC_OUT}, 0);
      tick();
    end
    check_eq("t3_pops_stalled", pop_log.size(), 2);
    READY_IN = 1'b1;
    drain(40);
    check_eq("t3_pops_total", pop_log.size(), 6);
    check_eq("t3_cnt_d0", {24'd0, CNT_D0}, 3);
    check_eq("t3_cnt_d1", {24'd0, CNT_D1}, 3);

    // Destination error: sticky, word still delivered
    do_reset();
    fifo_push(1'b0, 6'b111110);
    expect_word(1'b0, 6'b111110);
    tick();
    check_eq("t4_err_before_cap", {31'd0, ERR_DEST}, 0);
    tick();
    check_eq("t4_err_after_cap", {31'd0, ERR_DEST}, 1);
    fifo_push(1'b0, 6'b000011);
    expect_word(1'b0, 6'b000011);
    drain(20);
    check_eq("t4_err_sticky", {31'd0, ERR_DEST}, 1);
    check_eq("t4_cnt_d0", {24'd0, CNT_D0}, 2);
    do_reset();
    check_eq("t4_err_cleared", {31'd0, ERR_DEST}, 0);

    // 256 words from D1: counter wraps to 0
    for (int i = 0; i < 256; i++) begin
      fifo_push(1'b1, {1'b1, 5'(i)});
      expect_word(1'b1, {1'b1, 5'(i)});
    end
    drain(400);
    check_eq("t5_handshakes_d1", hs_d1, 256);
    check_eq("t5_cnt_d1_wrap", {24'd0, CNT_D1}, 0);
    check_eq("t5_cnt_d0", {24'd0, CNT_D0}, 0);

    // Reset the cycle after a pop discards the in-flight word
    do_reset();
    fifo_push(1'b1, 6'b100101);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
    tick();
    check_eq("t6_pops", pop_log.size(), 1);
    check_eq("t6_valid", {31'd0, VALID_OUT}, 0);
    check_eq("t6_cnt_d0", {24'd0, CNT_D0}, 0);
    check_eq("t6_cnt_d1", {24'd0, CNT_D1}, 0);
    check_eq("t6_err", {31'd0, ERR_DEST}, 0);

    // ENABLE dropped after a pop: popped word still delivered, no more pops
    do_reset();
    fifo_push(1'b0, 6'b000111);
    fifo_push(1'b0, 6'b001100);
    expect_word(1'b0, 6'b000111);
    tick();
    ENABLE = 1'b0;
    tick();
    check_eq("t7_valid", {31'd0, VALID_OUT}, 1);
    check_eq("t7_data", {26'd0, DATA_OUT}, 32'b000111);
    for (int i = 0; i < 4; i++) tick();
    check_eq("t7_pops_disabled", pop_log.size(), 1);
    check_eq("t7_cnt_d0", {24'd0, CNT_D0}, 1);
    check_eq("t7_valid_drained", {31'd0, VALID_OUT}, 0);
    ENABLE = 1'b1;
    expect_word(1'b0, 6'b001100);
    drain(20);
    check_eq("t7_pops_reenabled", pop_log.size(), 2);
    check_eq("t7_cnt_d0_final", {24'd0, CNT_D0}, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
